// File: rtl/wb_master_pkg.sv
// Shared command/response encodings for the pipelined Wishbone bus master.
// mk_rsp builds a response word for any data width up to MAX_DW.
package wb_master_pkg;

    localparam logic [1:0] CMD_SUB_RD      = 2'b00;
    localparam logic [1:0] CMD_SUB_WR      = 2'b01;
    localparam logic [1:0] CMD_SUB_ADDR    = 2'b10;
    localparam logic [1:0] CMD_SUB_SPECIAL = 2'b11;

    localparam logic [1:0] RSP_SUB_DATA    = 2'b00;
    localparam logic [1:0] RSP_SUB_ACK     = 2'b01;
    localparam logic [1:0] RSP_SUB_ADDR    = 2'b10;
    localparam logic [1:0] RSP_SUB_SPECIAL = 2'b11;

    localparam logic [2:0] SPC_RESET       = 3'h0;
    localparam logic [2:0] SPC_BUS_ERROR   = 3'h1;
    localparam logic [2:0] SPC_TIMEOUT     = 3'h2;

    localparam int MAX_DW = 64;

    // Places sub directly above a dw-bit payload; payload bits at dw and above must be zero.
    function automatic logic [MAX_DW+1:0] mk_rsp(input logic [1:0] sub,
                                                 input logic [MAX_DW-1:0] payload,
                                                 input int dw);
        return {2'b00, payload} | ({{MAX_DW{1'b0}}, sub} << dw);
    endfunction

endpackage

// File: rtl/wb_master_pipe_watchdog.sv
// Bus watchdog: counts cycles while running without a clear and pulses expired
// on the cycle the count reaches TIMEOUT. TIMEOUT of 0 disables it.
module wb_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign o_expired = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] count_reg;

            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    count_reg <= '0;
                end else if (i_clear || !i_run) begin
                    count_reg <= '0;
                end else begin
                    count_reg <= count_reg + CW'(1);
                end
            end

            assign o_expired = i_run && !i_clear && (count_reg == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/wb_master_pipe.sv
// Pipelined Wishbone B4 master fed by command words; returns one response word
// per completed beat, address set, abort or error.
module wb_master_pipe
    import wb_master_pkg::*;
#(
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int LGOUT   = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_cmd_stb,
    input  logic [DW+1:0]   i_cmd_word,
    output logic            o_cmd_busy,
    output logic            o_rsp_stb,
    output logic [DW+1:0]   o_rsp_word,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic            i_wb_err,
    input  logic [DW-1:0]   i_wb_data
);

    typedef logic [DW+1:0] word_t;
    localparam logic [LGOUT-1:0] MAXOUT = '1;

    function automatic word_t pack_rsp(input logic [1:0] sub, input logic [DW-1:0] payload);
        return word_t'(mk_rsp(sub, MAX_DW'(payload), DW));
    endfunction

    function automatic logic [DW-1:0] special_payload(input logic [2:0] code);
        return {code, {(DW-3){1'b0}}};
    endfunction

    logic              cyc_reg, stb_reg, we_reg, inc_reg;
    logic [AW-1:0]     addr_reg;
    logic [DW-1:0]     data_reg;
    logic [LGOUT-1:0]  nout_reg, nout_next;
    logic              rsp_stb_reg, reset_rsp_reg;
    word_t             rsp_word_reg, rsp_word_next;
    logic              rsp_valid_next;
    logic              stb_next, cyc_next;

    logic [1:0]        cmd_sub;
    logic [DW-1:0]     cmd_payload;
    logic              issue, ack_valid, bus_err, wd_expired, pending_err;
    logic              slots_full, dir_conflict;
    logic              accept, accept_rw, accept_addr, special_abort;
    logic [AW-1:0]     addr_field, addr_set;

    assign cmd_sub     = i_cmd_word[DW+1:DW];
    assign cmd_payload = i_cmd_word[DW-1:0];

    assign issue       = stb_reg && !i_wb_stall;
    assign ack_valid   = cyc_reg && i_wb_ack && (nout_reg != '0 || issue);
    assign bus_err     = cyc_reg && i_wb_err;
    assign pending_err = bus_err || wd_expired;

    // A strobe still waiting to issue already claims one of the outstanding slots.
    assign slots_full   = (nout_reg == MAXOUT) || (stb_reg && nout_reg == MAXOUT - LGOUT'(1));
    assign dir_conflict = cyc_reg && (cmd_sub == CMD_SUB_ADDR ||
                                      (!cmd_sub[1] && cmd_sub[0] != we_reg));
    assign o_cmd_busy   = (cmd_sub != CMD_SUB_SPECIAL) &&
                          ((stb_reg && i_wb_stall) || slots_full || pending_err || dir_conflict);

    assign accept        = i_cmd_stb && !o_cmd_busy;
    assign accept_rw     = accept && !cmd_sub[1];
    assign accept_addr   = accept && cmd_sub == CMD_SUB_ADDR;
    assign special_abort = accept && cmd_sub == CMD_SUB_SPECIAL &&
                           cmd_payload[DW-1:DW-3] == SPC_RESET;

    assign addr_field = cmd_payload[AW+1:2];
    assign addr_set   = cmd_payload[1] ? addr_reg + addr_field : addr_field;

    wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (i_wb_ack || issue),
        .i_run     (cyc_reg),
        .o_expired (wd_expired)
    );

    always_comb begin
        nout_next = nout_reg;
        if (issue && !ack_valid) begin
            nout_next = nout_reg + LGOUT'(1);
        end else if (!issue && ack_valid) begin
            nout_next = nout_reg - LGOUT'(1);
        end
        stb_next = accept_rw ? 1'b1 : (issue ? 1'b0 : stb_reg);
        cyc_next = accept_rw || (cyc_reg && (stb_next || nout_next != '0));
    end

    always_comb begin
        rsp_valid_next = 1'b1;
        rsp_word_next  = '0;
        if (reset_rsp_reg) begin
            rsp_word_next = pack_rsp(RSP_SUB_SPECIAL, special_payload(SPC_RESET));
        end else if (bus_err) begin
            rsp_word_next = pack_rsp(RSP_SUB_SPECIAL, special_payload(SPC_BUS_ERROR));
        end else if (wd_expired) begin
            rsp_word_next = pack_rsp(RSP_SUB_SPECIAL, special_payload(SPC_TIMEOUT));
        end else if (special_abort) begin
            rsp_word_next = pack_rsp(RSP_SUB_SPECIAL, special_payload(SPC_RESET));
        end else if (ack_valid) begin
            rsp_word_next = we_reg ? pack_rsp(RSP_SUB_ACK, '0) : pack_rsp(RSP_SUB_DATA, i_wb_data);
        end else if (accept_addr) begin
            rsp_word_next = pack_rsp(RSP_SUB_ADDR, DW'({addr_set, 1'b0, !cmd_payload[0]}));
        end else begin
            rsp_valid_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cyc_reg       <= 1'b0;
            stb_reg       <= 1'b0;
            we_reg        <= 1'b0;
            inc_reg       <= 1'b1;
            addr_reg      <= '0;
            data_reg      <= '0;
            nout_reg      <= '0;
            rsp_stb_reg   <= 1'b0;
            rsp_word_reg  <= '0;
            reset_rsp_reg <= 1'b1;
        end else begin
            reset_rsp_reg <= 1'b0;
            rsp_stb_reg   <= rsp_valid_next;
            rsp_word_reg  <= rsp_word_next;
            if (pending_err || special_abort) begin
                cyc_reg  <= 1'b0;
                stb_reg  <= 1'b0;
                nout_reg <= '0;
            end else begin
                cyc_reg  <= cyc_next;
                stb_reg  <= stb_next;
                nout_reg <= nout_next;
                if (issue) begin
                    addr_reg <= addr_reg + AW'(inc_reg);
                end
            end
            if (accept_rw) begin
                we_reg   <= cmd_sub[0];
                data_reg <= cmd_payload;
            end
            if (accept_addr) begin
                addr_reg <= addr_set;
                inc_reg  <= !cmd_payload[0];
            end
        end
    end

    assign o_wb_cyc   = cyc_reg;
    assign o_wb_stb   = stb_reg;
    assign o_wb_we    = we_reg;
    assign o_wb_addr  = addr_reg;
    assign o_wb_data  = data_reg;
    assign o_wb_sel   = '1;
    assign o_rsp_stb  = rsp_stb_reg;
    assign o_rsp_word = rsp_word_reg;

endmodule

// File: tb/tb_wb_master_pipe.sv
// Directed bench for wb_master_pipe: reset pulse, pipelined reads, address wrap,
// outstanding limit, error abort, watchdog timeout and special abort.
module tb_wb_master_pipe;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int LGOUT = 3;
    localparam int TIMEOUT = 16;

    localparam logic [DW+1:0] W_RESET   = 34'h3_0000_0000;
    localparam logic [DW+1:0] W_BUSERR  = 34'h3_2000_0000;
    localparam logic [DW+1:0] W_TIMEOUT = 34'h3_4000_0000;
    localparam logic [DW+1:0] W_WRACK   = 34'h1_0000_0000;
    localparam logic [DW+1:0] CMD_RD    = 34'h0_0000_0000;

    logic            clk = 1'b0;
    logic            i_reset_n;
    logic            i_cmd_stb;
    logic [DW+1:0]   i_cmd_word;
    logic            o_cmd_busy, o_rsp_stb;
    logic [DW+1:0]   o_rsp_word;
    logic            o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0]   o_wb_addr;
    logic [DW-1:0]   o_wb_data;
    logic [DW/8-1:0] o_wb_sel;
    logic            i_wb_stall, i_wb_err;
    wire             i_wb_ack;
    wire  [DW-1:0]   i_wb_data;

    logic            auto_ack, m_ack;
    logic [DW-1:0]   m_data;
    logic            s_v0 = 1'b0, s_v1 = 1'b0, s_ack = 1'b0;
    logic [AW-1:0]   s_a0 = '0, s_a1 = '0;
    logic [DW-1:0]   s_data = '0;

    typedef struct {
        logic [DW+1:0] word;
        int            cyc_no;
        logic          bus_cyc;
    } rsp_t;

    rsp_t          rsp_q[$];
    logic [AW-1:0] iss_addr_q[$];
    int            iss_cyc_q[$];
    int            cyc_cnt = 0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    wb_master_pipe #(.AW(AW), .DW(DW), .LGOUT(LGOUT), .TIMEOUT(TIMEOUT)) dut (
        .i_clk      (clk),
        .i_reset_n  (i_reset_n),
        .i_cmd_stb  (i_cmd_stb),
        .i_cmd_word (i_cmd_word),
        .o_cmd_busy (o_cmd_busy),
        .o_rsp_stb  (o_rsp_stb),
        .o_rsp_word (o_rsp_word),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_addr  (o_wb_addr),
        .o_wb_data  (o_wb_data),
        .o_wb_sel   (o_wb_sel),
        .i_wb_stall (i_wb_stall),
        .i_wb_ack   (i_wb_ack),
        .i_wb_err   (i_wb_err),
        .i_wb_data  (i_wb_data)
    );

    assign i_wb_ack  = s_ack | m_ack;
    assign i_wb_data = s_ack ? s_data : m_data;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Slave that acks each issued beat two cycles later, data = D0000000 | addr.
    always @(negedge clk) begin
        s_ack  <= auto_ack && s_v1;
        s_data <= 32'hD000_0000 | DW'(s_a1);
        s_v1   <= s_v0;
        s_a1   <= s_a0;
        s_v0   <= o_wb_stb && !i_wb_stall;
        s_a0   <= o_wb_addr;
    end

    always @(negedge clk) begin
        if (o_rsp_stb) rsp_q.push_back('{o_rsp_word, cyc_cnt, o_wb_cyc});
        if (o_wb_stb && !i_wb_stall && i_reset_n) begin
            iss_addr_q.push_back(o_wb_addr);
            iss_cyc_q.push_back(cyc_cnt + 1);
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [DW+1:0] word);
        int guard;
        guard = 0;
        @(negedge clk);
        #1;
        i_cmd_stb  = 1'b1;
        i_cmd_word = word;
        while (o_cmd_busy && guard < 100) begin
            step(1);
            guard++;
        end
        if (guard >= 100) chk("send_accept", 64'(o_cmd_busy), 64'd0);
        @(posedge clk);
        #1;
        i_cmd_stb = 1'b0;
        $display("cmd %h accepted at cycle %0d", word, cyc_cnt);
    endtask

    task automatic expect_rsp(input string tag, input logic [DW+1:0] exp, output rsp_t r);
        int guard;
        guard = 0;
        r = '{'0, 0, 1'b0};
        while (rsp_q.size() == 0 && guard < 100) begin
            step(1);
            guard++;
        end
        if (rsp_q.size() == 0) begin
            chk({tag, "_missing"}, 64'(rsp_q.size()), 64'd1);
        end else begin
            r = rsp_q.pop_front();
            $display("rsp %s word=%h cycle=%0d", tag, r.word, r.cyc_no);
            chk(tag, 64'(r.word), 64'(exp));
        end
    endtask

    initial begin
        rsp_t r;
        i_reset_n  = 1'b0;
        i_cmd_stb  = 1'b0;
        i_cmd_word = '0;
        i_wb_stall = 1'b0;
        i_wb_err   = 1'b0;
        m_ack      = 1'b0;
        m_data     = '0;
        auto_ack   = 1'b0;

        // Reset state and the single reset response
        step(3);
        chk("reset_cyc", 64'(o_wb_cyc), 64'd0);
        chk("reset_rsp_stb", 64'(o_rsp_stb), 64'd0);
        chk("reset_addr", 64'(o_wb_addr), 64'd0);
        i_reset_n = 1'b1;
        step(4);
        chk("reset_rsp_count", 64'(rsp_q.size()), 64'd1);
        expect_rsp("reset_rsp", W_RESET, r);
        chk("idle_cyc", 64'(o_wb_cyc), 64'd0);

        // Absolute address then four pipelined reads
        auto_ack = 1'b1;
        send({2'b10, 32'h0000_0100});
        expect_rsp("addr_echo_abs", 34'h2_0000_0101, r);
        for (int i = 0; i < 4; i++) send(CMD_RD);
        for (int i = 0; i < 4; i++) expect_rsp($sformatf("rd_data%0d", i), {2'b00, 32'hD000_0040 + i}, r);
        chk("rd_cyc_drop", 64'(r.bus_cyc), 64'd0);
        chk("rd_issue_count", 64'(iss_addr_q.size()), 64'd4);
        if (iss_addr_q.size() == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("rd_addr%0d", i), 64'(iss_addr_q[i]), 64'(32'h40 + i));
            chk("rd_consecutive", 64'(iss_cyc_q[3] - iss_cyc_q[0]), 64'd3);
            chk("rd_last_latency", 64'(r.cyc_no - iss_cyc_q[3]), 64'd2);
        end
        auto_ack = 1'b0;
        step(3);

        // Relative address wrap
        send({2'b10, 32'hFFFF_FFF0});
        expect_rsp("addr_echo_set", 34'h2_FFFF_FFF1, r);
        send({2'b10, 32'h0000_0022});
        expect_rsp("addr_echo_wrap", 34'h2_0000_0011, r);
        chk("addr_wrap", 64'(o_wb_addr), 64'h4);

        // Outstanding limit with a silent slave
        iss_addr_q.delete();
        iss_cyc_q.delete();
        for (int i = 0; i < 7; i++) send(CMD_RD);
        i_cmd_stb  = 1'b1;
        i_cmd_word = CMD_RD;
        step(2);
        chk("maxout_busy", 64'(o_cmd_busy), 64'd1);
        chk("maxout_issued", 64'(iss_addr_q.size()), 64'd7);
        chk("maxout_stb_low", 64'(o_wb_stb), 64'd0);
        m_ack  = 1'b1;
        m_data = 32'h1234_5678;
        step(1);
        m_ack = 1'b0;
        chk("maxout_busy_after_ack", 64'(o_cmd_busy), 64'd0);
        expect_rsp("maxout_data0", {2'b00, 32'h1234_5678}, r);
        @(posedge clk);
        #1;
        i_cmd_stb = 1'b0;
        step(2);
        chk("maxout_issued8", 64'(iss_addr_q.size()), 64'd8);
        for (int i = 0; i < 7; i++) begin
            m_ack  = 1'b1;
            m_data = 32'hA000_0000 + i;
            step(1);
        end
        m_ack = 1'b0;
        for (int i = 0; i < 7; i++) expect_rsp($sformatf("maxout_data%0d", i + 1), {2'b00, 32'hA000_0000 + i}, r);
        chk("maxout_cyc_drop", 64'(r.bus_cyc), 64'd0);

        // Error and ack together with three beats outstanding
        for (int i = 0; i < 3; i++) send(CMD_RD);
        step(2);
        chk("err_pre_cyc", 64'(o_wb_cyc), 64'd1);
        chk("err_pre_stb", 64'(o_wb_stb), 64'd0);
        m_ack    = 1'b1;
        i_wb_err = 1'b1;
        m_data   = 32'h0000_0BAD;
        step(1);
        m_ack    = 1'b0;
        i_wb_err = 1'b0;
        chk("err_cyc", 64'(o_wb_cyc), 64'd0);
        expect_rsp("bus_error", W_BUSERR, r);
        step(3);
        chk("err_no_data", 64'(rsp_q.size()), 64'd0);
        auto_ack = 1'b1;
        send(CMD_RD);
        expect_rsp("post_err_data", {2'b00, 32'hD000_000F}, r);
        chk("post_err_cyc_drop", 64'(r.bus_cyc), 64'd0);
        auto_ack = 1'b0;
        step(3);

        // Watchdog timeout, with a write held off during the read cycle
        send(CMD_RD);
        i_cmd_stb  = 1'b1;
        i_cmd_word = {2'b01, 32'hCAFE_F00D};
        step(5);
        chk("wr_busy_in_read", 64'(o_cmd_busy), 64'd1);
        expect_rsp("timeout", W_TIMEOUT, r);
        chk("timeout_latency", 64'(r.cyc_no - iss_cyc_q[$]), 64'd16);
        for (int g = 0; g < 50 && o_cmd_busy; g++) step(1);
        @(posedge clk);
        #1;
        i_cmd_stb = 1'b0;
        step(1);
        chk("wr_cyc", 64'(o_wb_cyc), 64'd1);
        chk("wr_we", 64'(o_wb_we), 64'd1);
        chk("wr_addr", 64'(o_wb_addr), 64'h11);
        chk("wr_data", 64'(o_wb_data), 64'hCAFE_F00D);
        step(1);
        m_ack = 1'b1;
        step(1);
        m_ack = 1'b0;
        expect_rsp("wr_ack", W_WRACK, r);
        chk("wr_cyc_drop", 64'(r.bus_cyc), 64'd0);

        // Special abort with a read outstanding
        send(CMD_RD);
        step(2);
        chk("abort_pre_cyc", 64'(o_wb_cyc), 64'd1);
        send({2'b11, 32'h0000_0000});
        chk("abort_cyc", 64'(o_wb_cyc), 64'd0);
        expect_rsp("abort_reset", W_RESET, r);
        step(5);
        chk("abort_quiet", 64'(rsp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
